instruction_fetch_unit: RTL and testbench

Fetch stage directly upstream of the control unit: holds the program counter, reads 32-bit instructions from instruction memory over a request/acknowledge handshake, and presents one registered instruction at a time with its 7-bit `Opcode` field. The control unit's `Opcode` input is driven from this block. Downstream backpressure is applied through `Stall`; branch and jump redirection through `Redirect`/`RedirectPC`.

---
 rtl/instruction_fetch_unit.sv | 84 ++++++++
 tb/tb_instruction_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, fetches one 32-bit word per request/ack handshake and
// presents a single registered instruction to the control unit.
module instruction_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  CLK,
  input  logic                  Reset,
  output logic                  IMemReq,
  output logic [ADDR_WIDTH-1:0] IMemAddr,
  input  logic                  IMemAck,
  input  logic [31:0]           IMemData,
  input  logic                  Stall,
  input  logic                  Redirect,
  input  logic [ADDR_WIDTH-1:0] RedirectPC,
  output logic [31:0]           Instr,
  output logic [6:0]            Opcode,
  output logic [ADDR_WIDTH-1:0] PCOut,
  output logic                  InstrValid
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StFull
  } state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_pc_out;
  logic [31:0]           r_instr;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;

  assign w_redirect_pc = {RedirectPC[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state  <= StIdle;
      r_pc     <= RESET_PC;
      r_pc_out <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: r_state <= StReq;
        StReq: begin
          // Redirect wins over a same-cycle ack: the fetched word is dropped.
          if (Redirect) begin
            r_pc    <= w_redirect_pc;
            r_valid <= 1'b0;
            r_state <= StReq;
          end else if (IMemAck) begin
            r_instr  <= IMemData;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            r_pc     <= r_pc + ADDR_WIDTH'(4);
            r_state  <= StFull;
          end
        end
        StFull: begin
          if (Redirect) begin
            r_pc    <= w_redirect_pc;
            r_valid <= 1'b0;
            r_state <= StReq;
          end else if (!Stall) begin
            r_valid <= 1'b0;
            r_state <= StReq;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Request is decoded from state so asynchronous reset drops it without a clock.
  assign IMemReq    = (r_state == StReq);
  assign IMemAddr   = r_pc;
  assign Instr      = r_instr;
  assign Opcode     = r_instr[6:0];
  assign PCOut      = r_pc_out;
  assign InstrValid = r_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed test-plan steps followed by a
// randomized phase, all checked against a transaction-level model of the fetch stage.
module tb_instruction_fetch_unit;

  localparam int unsigned AW = 32;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          IMemReq;
  logic [AW-1:0] IMemAddr;
  logic          IMemAck;
  logic [31:0]   IMemData;
  logic          Stall;
  logic          Redirect;
  logic [AW-1:0] RedirectPC;
  logic [31:0]   Instr;
  logic [6:0]    Opcode;
  logic [AW-1:0] PCOut;
  logic          InstrValid;

  int tests = 0;
  int fails = 0;

  // Model: whether fetching has started since reset, the next fetch address, and the
  // currently held instruction (if any). A request is pending whenever running and empty.
  bit          m_run;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcout;

  instruction_fetch_unit #(
    .ADDR_WIDTH(AW),
    .RESET_PC  (32'h0)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .IMemAck   (IMemAck),
    .IMemData  (IMemData),
    .Stall     (Stall),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .Instr     (Instr),
    .Opcode    (Opcode),
    .PCOut     (PCOut),
    .InstrValid(InstrValid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_valid = 0;
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pcout = 32'h0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    if (!Reset) model_reset();
    else if (!m_run) m_run = 1;
    else if (Redirect) begin
      m_pc    = RedirectPC & 32'hFFFF_FFFC;
      m_valid = 0;
    end else if (!m_valid) begin
      if (IMemAck) begin
        m_instr = IMemData;
        m_pcout = m_pc;
        m_valid = 1;
        m_pc    = m_pc + 32'd4;
      end
    end else if (!Stall) m_valid = 0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".req"},   {31'h0, IMemReq},    {31'h0, m_run && !m_valid});
    chk({ctx, ".addr"},  IMemAddr,            m_pc);
    chk({ctx, ".valid"}, {31'h0, InstrValid}, {31'h0, m_valid});
    chk({ctx, ".instr"}, Instr,               m_instr);
    chk({ctx, ".op"},    {25'h0, Opcode},     {25'h0, m_instr[6:0]});
    chk({ctx, ".pcout"}, PCOut,               m_pcout);
  endtask

  task automatic step(input string ctx);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(ctx);
  endtask

  task automatic drive(input bit ack, input logic [31:0] data, input bit stl, input bit rd,
                       input logic [31:0] rpc);
    IMemAck    = ack;
    IMemData   = data;
    Stall      = stl;
    Redirect   = rd;
    RedirectPC = rpc;
  endtask

  logic [31:0] stream [4] = '{32'h0000_0033, 32'h0000_2003, 32'h0000_2023, 32'h0000_0063};
  logic [6:0]  ops    [4] = '{7'h33, 7'h03, 7'h23, 7'h63};
  logic [31:0] held_addr;

  initial begin
    model_reset();
    Reset = 1'b0;
    drive(0, 32'h0, 0, 0, 32'h0);
    #1;
    check_all("reset0");
    step("reset1");
    step("reset2");

    // First fetch with a zero-wait memory
    Reset = 1'b1;
    drive(1, stream[0], 0, 0, 32'h0);
    step("first_req");
    chk("first_req_hi", {31'h0, IMemReq}, 32'h1);
    chk("first_addr0", IMemAddr, 32'h0);
    step("first_valid");
    chk("first_opcode", {25'h0, Opcode}, 32'h33);
    chk("first_pcout", PCOut, 32'h0);

    // Sequential stream; valid alternates each cycle
    for (int i = 1; i < 4; i++) begin
      IMemData = stream[i];
      step("stream_req");
      step("stream_full");
      chk("stream_op", {25'h0, Opcode}, {25'h0, ops[i]});
      chk("stream_pc", PCOut, 32'(i * 4));
    end

    // Three wait states, then hold the result under stall for five cycles
    drive(0, 32'hA5A5_0013, 0, 0, 32'h0);
    step("wait_enter");
    held_addr = IMemAddr;
    for (int i = 0; i < 3; i++) begin
      step("wait");
      chk("wait_addr_stable", IMemAddr, held_addr);
    end
    drive(1, 32'hA5A5_0013, 1, 0, 32'h0);
    step("wait_ack");
    IMemAck = 0;
    for (int i = 0; i < 4; i++) begin
      step("stall_hold");
      chk("stall_no_req", {31'h0, IMemReq}, 32'h0);
    end
    Stall = 0;
    step("stall_release");
    chk("stall_release_req", {31'h0, IMemReq}, 32'h1);

    // Redirect colliding with an ack in REQ
    drive(1, 32'hDEAD_BEEF, 0, 1, 32'h0000_0102);
    step("redir_req");
    chk("redir_req_addr", IMemAddr, 32'h0000_0100);
    chk("redir_req_valid", {31'h0, InstrValid}, 32'h0);

    // Redirect while FULL and stalled
    drive(1, 32'h0000_0013, 0, 0, 32'h0);
    step("redir_fill");
    drive(0, 32'h0, 1, 1, 32'h0000_0102);
    step("redir_full");
    chk("redir_full_addr", IMemAddr, 32'h0000_0100);
    chk("redir_full_valid", {31'h0, InstrValid}, 32'h0);

    // Wrap-around at the top of the address space
    drive(0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    step("wrap_redir");
    drive(1, 32'h0000_006F, 0, 0, 32'h0);
    step("wrap_ack");
    chk("wrap_pcout", PCOut, 32'hFFFF_FFFC);
    chk("wrap_next_addr", IMemAddr, 32'h0);

    // Asynchronous reset between edges while in REQ
    drive(0, 32'h0, 0, 0, 32'h0);
    step("mid_req");
    #2 Reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_req", {31'h0, IMemReq}, 32'h0);
    chk("mid_rst_valid", {31'h0, InstrValid}, 32'h0);
    check_all("mid_rst");
    step("mid_rst_hold");
    Reset = 1'b1;
    drive(1, 32'h0000_0037, 0, 0, 32'h0);
    step("restart_req");
    chk("restart_addr", IMemAddr, 32'h0);
    step("restart_valid");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
